// File: rtl/pattern_sequencer.sv
// pattern_sequencer: plays the first N entries of a 16x3-bit pattern set on
// eight one-hot LEDs with fixed on/off timing, then pulses done.
// Optional feature macro: PATTERN_SEQ_REPLAY_EN adds a replay input that
// replays the last latched set/length without re-latching the bus.
module pattern_sequencer #(
  parameter int ON_CYCLES  = 50_000_000,
  parameter int OFF_CYCLES = 25_000_000,
  parameter int MAX_LEN    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
`ifdef PATTERN_SEQ_REPLAY_EN
  input  logic                   replay,
`endif
  input  logic [4:0]             pat_len,
  input  logic [3*MAX_LEN-1:0]   patterns,
  output logic [7:0]             led,
  output logic                   led_valid,
  output logic [3:0]             cur_idx,
  output logic                   busy,
  output logic                   done
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [4:0]    LEN_MAX  = 5'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, SHOW, GAP, FIN} state_t;

  state_t                   state;
  logic [MAX_LEN-1:0][2:0]  set_q;
  logic [4:0]               len_q;
  logic [TW-1:0]            timer;

  logic       replay_req;
  logic       go;
  logic [4:0] len_in;
  logic [4:0] go_len;
  logic [2:0] go_first;
  logic       last;
  logic [3:0] nxt_idx;

`ifdef PATTERN_SEQ_REPLAY_EN
  assign replay_req = replay;
`else
  assign replay_req = 1'b0;
`endif

  // Lengths beyond the set size play the whole set.
  assign len_in   = (pat_len > LEN_MAX) ? LEN_MAX : pat_len;
  // start has priority over replay; replay reuses the latched set.
  assign go       = start | replay_req;
  assign go_len   = start ? len_in : len_q;
  assign go_first = start ? patterns[2:0] : set_q[0];
  assign last     = ({1'b0, cur_idx} == (len_q - 5'd1));
  assign nxt_idx  = cur_idx + 4'd1;

  // Playback FSM; every output is a register updated on state transitions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      set_q     <= '0;
      len_q     <= '0;
      timer     <= '0;
      led       <= '0;
      led_valid <= 1'b0;
      cur_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            cur_idx <= '0;
            busy    <= 1'b1;
            // A zero-length start leaves the previously latched set intact.
            if (start && len_in != 5'd0) begin
              set_q <= patterns;
              len_q <= len_in;
            end
            if (go_len != 5'd0) begin
              state     <= SHOW;
              led       <= 8'b1 << go_first;
              led_valid <= 1'b1;
              timer     <= ON_LOAD;
            end else begin
              state <= FIN;
              done  <= 1'b1;
              timer <= '0;
            end
          end
        end
        SHOW: begin
          if (timer == '0) begin
            state     <= GAP;
            led       <= '0;
            led_valid <= 1'b0;
            timer     <= OFF_LOAD;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        GAP: begin
          if (timer == '0) begin
            if (last) begin
              state <= FIN;
              done  <= 1'b1;
              timer <= '0;
            end else begin
              state     <= SHOW;
              cur_idx   <= nxt_idx;
              led       <= 8'b1 << set_q[nxt_idx];
              led_valid <= 1'b1;
              timer     <= ON_LOAD;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: randomized playback scenarios checked cycle by cycle
// against a timeline model computed from entry index and on/off phase.
module tb_pattern_sequencer;

  localparam int ON  = 4;
  localparam int OFF = 2;
  localparam int PER = ON + OFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        replay = 1'b0;
  logic [4:0]  pat_len = '0;
  logic [47:0] patterns = '0;
  logic [7:0]  led;
  logic        led_valid;
  logic [3:0]  cur_idx;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  pattern_sequencer #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .MAX_LEN(16)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
`ifdef PATTERN_SEQ_REPLAY_EN
    .replay(replay),
`endif
    .pat_len(pat_len),
    .patterns(patterns),
    .led(led),
    .led_valid(led_valid),
    .cur_idx(cur_idx),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Drives one playback (via start or replay) and compares every cycle up to
  // one past done against the expected timeline for set pset / length plen.
  task automatic run_playback(input logic [47:0] pset, input logic [4:0] plen,
                              input bit mutate, input bit via_replay, input string tag);
    int L, total, k, ph;
    logic [2:0] e [16];
    logic [15:0] exp_v, got_v;
    logic [7:0] eled;
    L = (plen > 16) ? 16 : int'(plen);
    total = L * PER + 1;
    for (int i = 0; i < 16; i++) e[i] = pset[3*i +: 3];
    @(negedge clk);
    if (via_replay) begin
      patterns = 48'({$urandom(), $urandom()});
      pat_len  = 5'($urandom_range(0, 31));
      replay   = 1'b1;
    end else begin
      patterns = pset;
      pat_len  = plen;
      start    = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    replay = 1'b0;
    for (int c = 1; c <= total + 1; c++) begin
      if (c <= L * PER) begin
        k = (c - 1) / PER;
        ph = (c - 1) % PER;
        eled = (ph < ON) ? (8'b1 << e[k]) : 8'h00;
        exp_v = {eled, (ph < ON), 4'(k), 1'b1, 1'b0};
      end else begin
        k = (L == 0) ? 0 : L - 1;
        exp_v = {8'h00, 1'b0, 4'(k), (c == total), (c == total)};
      end
      got_v = {led, led_valid, cur_idx, busy, done};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL %s cycle%0d led/vld/idx/busy/done got=%h/%b/%0d/%b/%b want=%h/%b/%0d/%b/%b",
                 tag, c, got_v[15:8], got_v[7], got_v[6:3], got_v[1], got_v[0],
                 exp_v[15:8], exp_v[7], exp_v[6:3], exp_v[1], exp_v[0]);
      end
      if (mutate && c < total - 1) begin
        start    = 1'($urandom_range(0, 1));
        patterns = 48'({$urandom(), $urandom()});
        pat_len  = 5'($urandom_range(0, 31));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({led, led_valid, cur_idx, busy, done} !== 15'h0) begin
      failures++;
      $display("FAIL reset_state got=%h want=0", {led, led_valid, cur_idx, busy, done});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fixed();
    // entries 0..2 = 5,0,7
    run_playback(48'({3'd7, 3'd0, 3'd5}), 5'd3, 1'b0, 1'b0, "fixed_507");
  endtask

  task automatic test_zero_len();
    run_playback(48'({$urandom(), $urandom()}), 5'd0, 1'b0, 1'b0, "zero_len");
  endtask

  task automatic test_clamp();
    logic [47:0] ones;
    int max_idx;
    ones = '0;
    for (int i = 0; i < 16; i++) ones[3*i +: 3] = 3'd1;
    max_idx = 0;
    fork
      run_playback(ones, 5'd20, 1'b0, 1'b0, "clamp20");
      begin
        for (int c = 0; c < 16 * PER + 4; c++) begin
          @(posedge clk);
          #1 if (int'(cur_idx) > max_idx) max_idx = int'(cur_idx);
        end
      end
    join
    checks++;
    if (max_idx != 15) begin
      failures++;
      $display("FAIL clamp_max_idx got=%0d want=15", max_idx);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++)
      run_playback(48'({$urandom(), $urandom()}), 5'($urandom_range(1, 16)), 1'b0, 1'b0, "random");
  endtask

  task automatic test_mid_changes();
    for (int n = 0; n < 3; n++)
      run_playback(48'({$urandom(), $urandom()}), 5'($urandom_range(1, 16)), 1'b1, 1'b0, "mid_change");
  endtask

  task automatic test_back_to_back();
    // start held high: one-entry playback, FIN, one IDLE cycle, then relaunch
    @(negedge clk);
    patterns = 48'({$urandom(), $urandom()});
    patterns[2:0] = 3'd6;
    pat_len = 5'd1;
    start = 1'b1;
    repeat (PER + 3) @(negedge clk);
    checks++;
    if ({led, led_valid, busy, done} !== {8'h40, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL retrigger got=%h/%b/%b/%b want=40/1/1/0", led, led_valid, busy, done);
    end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    patterns = 48'({$urandom(), $urandom()});
    pat_len = 5'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({led, led_valid, cur_idx, busy, done} !== 15'h0) begin
      failures++;
      $display("FAIL reset_mid_async got=%h want=0", {led, led_valid, cur_idx, busy, done});
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({led, led_valid, busy, done} !== 11'h0) begin
      failures++;
      $display("FAIL reset_mid_idle got=%h want=0", {led, led_valid, busy, done});
    end
  endtask

`ifdef PATTERN_SEQ_REPLAY_EN
  task automatic test_replay();
    logic [47:0] s;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    // replay with nothing latched ends immediately
    run_playback('0, 5'd0, 1'b0, 1'b1, "replay_empty");
    s = 48'({3'd4, 3'd3});
    run_playback(s, 5'd2, 1'b0, 1'b0, "replay_first");
    run_playback(s, 5'd2, 1'b0, 1'b1, "replay_again");
  endtask
`endif

  initial begin
    test_reset();
    test_fixed();
    test_zero_len();
    test_clamp();
    test_random();
    test_mid_changes();
    test_back_to_back();
    test_reset_mid();
`ifdef PATTERN_SEQ_REPLAY_EN
    test_replay();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
